// File: rtl/picnic_challenge_expand.sv
// Picnic3 challenge expansion: rejection-samples TAU distinct rounds and one party per
// round from a stream of digests, then emits the (round, party) pairs in acceptance order.
module picnic_challenge_expand #(
    parameter int T         = 250,
    parameter int TAU       = 36,
    parameter int N_PARTIES = 16,
    parameter int DIGEST_W  = 256,
    localparam int RW       = $clog2(T),
    localparam int PW       = $clog2(N_PARTIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                dig_ready,
    input  logic                dig_valid,
    input  logic [DIGEST_W-1:0] dig_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RW-1:0]       out_round,
    output logic [PW-1:0]       out_party,
    output logic                out_last,
    output logic [T-1:0]        chal_map,
    output logic                done
);

    localparam int CW = $clog2(TAU + 1);
    localparam int IW = $clog2(DIGEST_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(TAU - 1);

    typedef enum logic [2:0] {IDLE, WAIT_C, SCAN_C, WAIT_P, SCAN_P, EMIT} state_t;

    state_t               state;
    logic [DIGEST_W-1:0]  dig_reg;
    logic [RW-1:0]        list  [TAU];
    logic [PW-1:0]        party [TAU];
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        pcnt;
    logic [CW-1:0]        eidx;
    logic [IW-1:0]        cidx;

    logic [RW-1:0]        c_val;
    logic [PW-1:0]        p_val;
    logic                 c_acc;
    logic                 p_acc;
    logic                 c_last;
    logic                 p_last;
    logic [CW-1:0]        eidx_nxt;

    always_comb begin
        c_val    = dig_reg[int'(cidx)*RW +: RW];
        p_val    = dig_reg[int'(cidx)*PW +: PW];
        // chal_map is read before the same-edge update, so a repeat chunk next cycle sees it set
        c_acc    = (int'(c_val) < T) && !chal_map[c_val];
        p_acc    = int'(p_val) < N_PARTIES;
        c_last   = int'(cidx) == (DIGEST_W / RW - 1);
        p_last   = int'(cidx) == (DIGEST_W / PW - 1);
        eidx_nxt = eidx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dig_ready <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            out_round <= '0;
            out_party <= '0;
            chal_map  <= '0;
            cnt       <= '0;
            pcnt      <= '0;
            eidx      <= '0;
            cidx      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= WAIT_C;
                        busy      <= 1'b1;
                        dig_ready <= 1'b1;
                        chal_map  <= '0;
                        cnt       <= '0;
                        pcnt      <= '0;
                        eidx      <= '0;
                        cidx      <= '0;
                    end
                end
                WAIT_C, WAIT_P: begin
                    if (dig_valid) begin
                        dig_ready <= 1'b0;
                        cidx      <= '0;
                        state     <= (state == WAIT_C) ? SCAN_C : SCAN_P;
                    end
                end
                SCAN_C: begin
                    cidx <= cidx + 1'b1;
                    if (c_acc) begin
                        chal_map[c_val] <= 1'b1;
                        cnt             <= cnt + 1'b1;
                    end
                    if (c_acc && cnt == CNT_LAST) begin
                        state     <= WAIT_P;
                        dig_ready <= 1'b1;
                    end else if (c_last) begin
                        state     <= WAIT_C;
                        dig_ready <= 1'b1;
                    end
                end
                SCAN_P: begin
                    cidx <= cidx + 1'b1;
                    if (p_acc) pcnt <= pcnt + 1'b1;
                    if (p_acc && pcnt == CNT_LAST) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_round <= list[0];
                        out_party <= (pcnt == '0) ? p_val : party[0];
                        out_last  <= (TAU == 1);
                        eidx      <= '0;
                    end else if (p_last) begin
                        state     <= WAIT_P;
                        dig_ready <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            eidx      <= eidx_nxt;
                            out_round <= list[eidx_nxt];
                            out_party <= party[eidx_nxt];
                            out_last  <= (eidx_nxt == CNT_LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath storage carries no reset; the FSM decides when its contents are meaningful
    always_ff @(posedge clk) begin
        if ((state == WAIT_C || state == WAIT_P) && dig_valid) dig_reg <= dig_data;
        if (state == SCAN_C && c_acc) list[cnt] <= c_val;
        if (state == SCAN_P && p_acc) party[pcnt] <= p_val;
    end

endmodule

// File: doc/picnic_challenge_expand.md
# picnic_challenge_expand

Downstream of the commitment/verify stage, this block turns the challenge-hash digest stream into the Picnic3 opened-round list. It rejection-samples TAU distinct round indices and then one party index per selected round, pulling 256-bit digests from the external SHAKE core through a valid/ready handshake. It streams the resulting (round, party) pairs to the response-building stage.

## Interface
- T, 250, number of MPC rounds; round index width RW = clog2(T)
- TAU, 36, number of opened rounds
- N_PARTIES, 16, parties per round; party width PW = clog2(N_PARTIES)
- DIGEST_W, 256, digest width; must be a multiple of RW and of PW
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin expansion; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- dig_ready  out  1  block requests one digest
- dig_valid  in  1  digest present
- dig_data  in  DIGEST_W  digest; chunk k = dig_data[k*W +: W], with k ascending from 0
- out_valid  out  1  pair valid
- out_ready  in  1  consumer accepts pair
- out_round  out  RW  selected round index
- out_party  out  PW  unopened party for that round
- out_last  out  1  marks beat TAU-1
- chal_map  out  T  bit r set when round r is selected; stable from end of C phase until next start
- done  out  1  one-cycle pulse after the last beat handshake

## Operation
- States: IDLE, WAIT_C, SCAN_C, WAIT_P, SCAN_P, EMIT.
- IDLE: start goes to WAIT_C, clears chal_map, the accepted count and the chunk index. start in any other state is ignored.
- WAIT_C / WAIT_P: dig_ready=1. A digest transfers on dig_valid&&dig_ready into an internal register. The chunk index resets to 0 and the FSM goes to SCAN_C / SCAN_P. dig_ready=0 in all other states.
- SCAN_C: one RW-bit chunk per cycle.
  - Reject if value ≥ T, or if chal_map[value] is already set.
  - Otherwise set chal_map[value], write value to list[count], and increment count.
  - If count reaches TAU: go to WAIT_P, discarding the remaining chunks.
  - If the last chunk (DIGEST_W/RW−1) is consumed with count < TAU: go to WAIT_C for the next digest.
- SCAN_P: the P phase always starts on a fresh digest. One PW-bit chunk per cycle.
  - Reject if value ≥ N_PARTIES; this never happens when N_PARTIES is a power of two.
  - Otherwise write party[pcount] and increment pcount.
  - If pcount reaches TAU: go to EMIT, discarding the remaining chunks.
  - If the digest is exhausted first: go to WAIT_P.
- EMIT: beat i presents list[i] and party[i], in acceptance order. out_valid=1 and the outputs are held stable until out_ready. out_last=1 on i=TAU−1. The handshake on the last beat gives done=1 the next cycle and returns to IDLE.
- Storage: list is TAU×RW, party is TAU×PW, chal_map is a T-bit bitmap.

## Timing
- Reset values:
  - State IDLE.
  - busy, dig_ready, out_valid, out_last, done all 0.
  - out_round, out_party, chal_map all 0.
  - All counters 0.
- Reset mid-operation: return to IDLE on the next edge. Any in-flight digest is dropped and nothing is emitted.
- start to dig_ready=1: one cycle.
- Digest handshake to first chunk evaluated: one cycle. Then one chunk per cycle, with no bubbles within a digest.
- Digest exhausted to dig_ready=1: the next cycle.
- EMIT sustains one beat per cycle when out_ready is held high.
- A duplicate chunk within the same digest is rejected. This works because chal_map updates in the same cycle the chunk is accepted.
- dig_valid while dig_ready=0 is ignored.

## Test plan
- Sequential digests:
  - Stimulus: C digest 1 bytes = 0x00..0x1F; C digest 2 bytes = 0x20..0x3F; P digest nibble j = j mod 16.
  - Response: 32 accepts from the first digest and 4 from the second, so rounds 0..35. Parties 0..15,0..15,0..3. chal_map[35:0] all set.
- Rejection:
  - Stimulus: C digest 1 bytes all 0xFA..0xFF, then 0x07, 0x07, 0x07.
  - Response: only round 7 accepted from that digest. A second digest is requested. chal_map has no bits ≥ 250.
- Backpressure:
  - Stimulus: out_ready toggles every other cycle during EMIT.
  - Response: out_round/out_party stable while stalled. Exactly 36 beats, out_last on the 36th, done one cycle after its handshake.
- Digest stall:
  - Stimulus: dig_valid held low for 10 cycles in WAIT_C.
  - Response: dig_ready stays 1, no state change, chunk processing resumes one cycle after the handshake.
- Reset mid-SCAN_C:
  - Stimulus: reset asserted after 20 accepted rounds.
  - Response: next cycle busy=0, chal_map=0, out_valid=0. A new start reproduces the full scenario 1 result.
- start while busy:
  - Stimulus: pulse start during SCAN_P.
  - Response: ignored, and the output sequence is identical to scenario 1.
